// File: rtl/mips_pkg.sv
// Shared types and constants for the instruction fetch path.
package mips_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        VALID = 2'd3
    } fetch_state_e;

    localparam int WORD_BYTES = 4;
    localparam int INSTR_W    = 32;

    localparam logic [7:0] DEFAULT_RESET_PC = 8'h00;

endpackage

// File: rtl/word_assembler.sv
// Big-endian shift-in register: the first byte shifted in ends up in the top byte
// after a full word has been loaded.
module word_assembler
    import mips_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               shift_en,
    input  logic [7:0]         byte_in,
    output logic [INSTR_W-1:0] word
);

    logic [INSTR_W-1:0] word_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q <= '0;
        end else if (clear) begin
            word_q <= '0;
        end else if (shift_en) begin
            word_q <= {word_q[INSTR_W-9:0], byte_in};
        end
    end

    assign word = word_q;

endmodule

// File: rtl/inst_fetch_unit.sv
// Fetch stage: walks the PC through byte-wide instruction memory, assembles 32-bit
// big-endian words and hands them to decode over a valid/ready handshake.
//
//   state | meaning
//   IDLE  | one cycle after reset release, no reads
//   ISSUE | byte reads pc+0..pc+3, capturing the byte from the previous read
//   DRAIN | no read, capture the last returning byte
//   VALID | instruction presented, held until accepted
module inst_fetch_unit
    import mips_pkg::*;
#(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
    input  logic               clk,
    input  logic               rst,
    output logic               mem_rd_en,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic [7:0]         mem_rdata,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic [ADDR_W-1:0]  pc_plus4,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic               misalign_err
);

    localparam logic [1:0]        LAST_CNT = 2'(WORD_BYTES - 1);
    localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(WORD_BYTES);

    fetch_state_e      state_q;
    logic [1:0]        cnt_q;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] instr_pc_q;
    logic [ADDR_W-1:0] pc_plus4_q;
    logic              instr_valid_q;
    logic              mem_rd_en_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic              misalign_q;

    logic              redirect_take;
    logic [ADDR_W-1:0] redirect_aligned;
    logic              shift_en;
    logic [INSTR_W-1:0] word;

    assign redirect_take    = redirect_valid && (state_q != IDLE);
    assign redirect_aligned = {redirect_pc[ADDR_W-1:2], 2'b00};

    // A byte only lands when a read was issued last cycle under the current PC;
    // the read at cnt=0 has nothing in front of it, which also drops the stale
    // byte that returns right after a redirect.
    assign shift_en = !redirect_take &&
                      (((state_q == ISSUE) && (cnt_q != 2'd0)) || (state_q == DRAIN));

    word_assembler u_word_assembler (
        .clk      (clk),
        .rst      (rst),
        .clear    (redirect_take),
        .shift_en (shift_en),
        .byte_in  (mem_rdata),
        .word     (word)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= 2'd0;
            pc_q          <= RESET_PC;
            instr_pc_q    <= '0;
            pc_plus4_q    <= '0;
            instr_valid_q <= 1'b0;
            mem_rd_en_q   <= 1'b0;
            mem_addr_q    <= '0;
            misalign_q    <= 1'b0;
        end else begin
            misalign_q <= 1'b0;
            if (redirect_take) begin
                pc_q          <= redirect_aligned;
                cnt_q         <= 2'd0;
                state_q       <= ISSUE;
                mem_rd_en_q   <= 1'b1;
                mem_addr_q    <= redirect_aligned;
                instr_valid_q <= 1'b0;
                misalign_q    <= (redirect_pc[1:0] != 2'b00);
            end else begin
                case (state_q)
                    IDLE: begin
                        state_q     <= ISSUE;
                        cnt_q       <= 2'd0;
                        mem_rd_en_q <= 1'b1;
                        mem_addr_q  <= pc_q;
                    end
                    ISSUE: begin
                        if (cnt_q == LAST_CNT) begin
                            state_q     <= DRAIN;
                            mem_rd_en_q <= 1'b0;
                        end else begin
                            cnt_q      <= cnt_q + 2'd1;
                            mem_addr_q <= pc_q + ADDR_W'(cnt_q) + ADDR_W'(1);
                        end
                    end
                    DRAIN: begin
                        state_q       <= VALID;
                        instr_valid_q <= 1'b1;
                        instr_pc_q    <= pc_q;
                        pc_plus4_q    <= pc_q + STEP;
                    end
                    VALID: begin
                        if (instr_ready) begin
                            pc_q          <= pc_q + STEP;
                            cnt_q         <= 2'd0;
                            state_q       <= ISSUE;
                            mem_rd_en_q   <= 1'b1;
                            mem_addr_q    <= pc_q + STEP;
                            instr_valid_q <= 1'b0;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign mem_rd_en    = mem_rd_en_q;
    assign mem_addr     = mem_addr_q;
    assign instr        = word;
    assign instr_pc     = instr_pc_q;
    assign pc_plus4     = pc_plus4_q;
    assign instr_valid  = instr_valid_q;
    assign misalign_err = misalign_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Scoreboard bench for inst_fetch_unit: expected instructions are queued as each
// fetch is set up and compared whenever the DUT completes a handshake.
module tb_inst_fetch_unit;

    logic        clk;
    logic        rst;
    logic        mem_rd_en;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_rdata;
    logic        redirect_valid;
    logic [7:0]  redirect_pc;
    logic [31:0] instr;
    logic [7:0]  instr_pc;
    logic [7:0]  pc_plus4;
    logic        instr_valid;
    logic        instr_ready;
    logic        misalign_err;

    typedef struct packed {
        logic [31:0] instr;
        logic [7:0]  pc;
        logic [7:0]  p4;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] mem [256];
    int         n_checks = 0;
    int         n_err    = 0;

    inst_fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .mem_rd_en      (mem_rd_en),
        .mem_addr       (mem_addr),
        .mem_rdata      (mem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .pc_plus4       (pc_plus4),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .misalign_err   (misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One-cycle-latency memory; a filler byte when not reading exposes stray captures.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= mem[mem_addr];
        else           mem_rdata <= 8'hEE;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic exp_t make_exp(input logic [7:0] pc);
        exp_t e;
        logic [7:0] a1, a2, a3;
        a1 = pc + 8'd1;
        a2 = pc + 8'd2;
        a3 = pc + 8'd3;
        e.instr = {mem[pc], mem[a1], mem[a2], mem[a3]};
        e.pc    = pc;
        e.p4    = pc + 8'd4;
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst && instr_valid && instr_ready) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_handshake", {24'h0, instr_pc}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_instr", instr, e.instr);
                check("sb_instr_pc", {24'h0, instr_pc}, {24'h0, e.pc});
                check("sb_pc_plus4", {24'h0, pc_plus4}, {24'h0, e.p4});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string tag, output int n);
        n = 0;
        while (!instr_valid && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_valid_timeout"}, {31'h0, instr_valid}, 32'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hA5;
        mem[0] = 8'h20; mem[1] = 8'h08; mem[2] = 8'h00; mem[3] = 8'h05;

        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 8'h00;
        instr_ready    = 1'b1;
        tick();
        tick();
        check("rst_instr", instr, 32'h0);
        check("rst_valid", {31'h0, instr_valid}, 32'h0);
        check("rst_rd_en", {31'h0, mem_rd_en}, 32'h0);
        check("rst_addr", {24'h0, mem_addr}, 32'h0);
        check("rst_instr_pc", {24'h0, instr_pc}, 32'h0);
        check("rst_pc_plus4", {24'h0, pc_plus4}, 32'h0);
        check("rst_misalign", {31'h0, misalign_err}, 32'h0);

        // Basic fetch from reset with ready high.
        sb.push_back(make_exp(8'h00));
        rst = 1'b0;
        check("idle_rd_en", {31'h0, mem_rd_en}, 32'h0);
        tick();
        check("t1_rd_en", {31'h0, mem_rd_en}, 32'h1);
        check("t1_addr0", {24'h0, mem_addr}, 32'h0);
        for (int k = 1; k < 4; k++) begin
            tick();
            check("t1_addr_seq", {24'h0, mem_addr}, k);
        end
        tick();
        check("t1_drain_rd_en", {31'h0, mem_rd_en}, 32'h0);
        check("t1_drain_valid", {31'h0, instr_valid}, 32'h0);
        tick();
        check("t1_latency_valid", {31'h0, instr_valid}, 32'h1);
        tick();
        check("t1_next_addr", {24'h0, mem_addr}, 32'h4);
        check("t1_next_valid", {31'h0, instr_valid}, 32'h0);

        // Back-pressure: hold the word at pc 4.
        instr_ready = 1'b0;
        sb.push_back(make_exp(8'h04));
        wait_valid("t2", n);
        check("t2_latency", n, 5);
        for (int k = 0; k < 10; k++) begin
            tick();
            check("t2_hold_instr", instr, make_exp(8'h04).instr);
            check("t2_hold_pc", {24'h0, instr_pc}, 32'h4);
            check("t2_hold_rd_en", {31'h0, mem_rd_en}, 32'h0);
        end
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        check("t2_next_addr", {24'h0, mem_addr}, 32'h8);
        check("t2_next_rd_en", {31'h0, mem_rd_en}, 32'h1);

        // Redirect to 0x40 during cnt=2 of the fetch at 0x08.
        tick();
        tick();
        check("t3_addr_cnt2", {24'h0, mem_addr}, 32'hA);
        redirect_valid = 1'b1;
        redirect_pc    = 8'h40;
        tick();
        redirect_valid = 1'b0;
        check("t3_redirect_addr", {24'h0, mem_addr}, 32'h40);
        check("t3_no_misalign", {31'h0, misalign_err}, 32'h0);
        sb.push_back(make_exp(8'h40));
        wait_valid("t3", n);
        check("t3_latency", n, 5);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;

        // Misaligned redirect target 0x42 while fetching 0x44.
        redirect_valid = 1'b1;
        redirect_pc    = 8'h42;
        tick();
        redirect_valid = 1'b0;
        check("t4_misalign_pulse", {31'h0, misalign_err}, 32'h1);
        check("t4_aligned_addr", {24'h0, mem_addr}, 32'h40);
        tick();
        check("t4_misalign_clear", {31'h0, misalign_err}, 32'h0);
        sb.push_back(make_exp(8'h40));
        wait_valid("t4", n);

        // Redirect coincident with handshake: word consumed, target beats pc+4.
        instr_ready    = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 8'hFC;
        tick();
        redirect_valid = 1'b0;
        instr_ready    = 1'b0;
        check("t4b_target_addr", {24'h0, mem_addr}, 32'hFC);
        check("t4b_valid_drop", {31'h0, instr_valid}, 32'h0);

        // Wrap-around at the top of the address space.
        sb.push_back(make_exp(8'hFC));
        wait_valid("t5_fc", n);
        check("t5_fc_pc_plus4", {24'h0, pc_plus4}, 32'h0);
        instr_ready = 1'b1;
        tick();
        check("t5_wrap_addr", {24'h0, mem_addr}, 32'h0);
        sb.push_back(make_exp(8'h00));
        wait_valid("t5_wrap", n);
        tick();
        instr_ready = 1'b0;
        check("t6_fetch_addr", {24'h0, mem_addr}, 32'h4);

        // Async reset during DRAIN of the fetch at 0x04.
        for (int k = 0; k < 4; k++) tick();
        check("t6_drain_rd_en", {31'h0, mem_rd_en}, 32'h0);
        check("t6_drain_addr", {24'h0, mem_addr}, 32'h7);
        #2;
        rst = 1'b1;
        #1;
        check("t6_async_instr", instr, 32'h0);
        check("t6_async_addr", {24'h0, mem_addr}, 32'h0);
        check("t6_async_pc_plus4", {24'h0, pc_plus4}, 32'h0);
        check("t6_async_instr_pc", {24'h0, instr_pc}, 32'h0);
        check("t6_async_valid", {31'h0, instr_valid}, 32'h0);
        tick();
        rst = 1'b0;
        tick();
        check("t6_restart_addr", {24'h0, mem_addr}, 32'h0);
        check("t6_restart_rd_en", {31'h0, mem_rd_en}, 32'h1);
        sb.push_back(make_exp(8'h00));
        instr_ready = 1'b1;
        wait_valid("t6", n);
        check("t6_latency", n, 5);
        tick();
        instr_ready = 1'b0;
        tick();

        check("sb_leftover", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
